booth_seq_multiplier: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier with valid/ready handshakes on both sides. It is the area-reduced successor to the 32-bit combinational signed array multiplier. It retires two multiplier bits per clock, supports signed or unsigned operation per transaction, and sits between an operand-issue stage and a result consumer in the arithmetic datapath.

---
 rtl/booth_mul_pkg.sv | 27 ++
 rtl/booth_r4_enc.sv | 22 ++
 rtl/booth_seq_multiplier.sv | 150 +++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//
// Contents:
//   state_e        - controller states (idle, digit iteration, result held)
//   booth_digit_t  - decoded Booth digit select {neg, one, two}
//   num_digits()   - radix-4 digits needed for a WIDTH-bit operand pair
package booth_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Operands are widened to WIDTH+2 bits, so WIDTH/2+1 digits cover them.
  function automatic int unsigned num_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a digit select.
//
// Ports:
//   window  in  3  {x[2i+1], x[2i], x[2i-1]}
//   digit   out 3  {neg, one, two} select for the digit in {-2,-1,0,+1,+2}
module booth_r4_enc
  import booth_mul_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  always_comb begin
    digit     = '0;
    // 111 and 000 both mean zero, so neg is suppressed for 111.
    digit.neg = window[2] & ~(window[1] & window[0]);
    digit.one = window[1] ^ window[0];
    digit.two = (window[2] & ~window[1] & ~window[0]) |
                (~window[2] & window[1] & window[0]);
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, two multiplier bits retired per clock.
//
// Parameters:
//   WIDTH      operand width (even, >= 4)
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands/mode valid
//   in_ready   out  1        accepting a transaction (idle only)
//   a          in   WIDTH    multiplicand
//   x          in   WIDTH    multiplier
//   sgn        in   1        1: two's complement operands, 0: unsigned
//   out_valid  out  1        p holds a completed product
//   out_ready  in   1        consumer takes p
//   p          out  2*WIDTH  registered product
//   busy       out  1        calculating or holding a result
//
// Build option: define MUL_SIGNED_EN to honour sgn; otherwise sgn is ignored
// and all operands are treated as unsigned.
module booth_seq_multiplier
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   x,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned NumDig = num_digits(WIDTH);
  localparam int unsigned CntW   = $clog2(NumDig);
  localparam int unsigned OpW    = WIDTH + 2;
  localparam int unsigned AccW   = WIDTH + 4;
  localparam int unsigned PairW  = AccW + OpW;

  state_e             state_q, state_d;
  logic [OpW-1:0]     a_q, a_d;
  logic [OpW-1:0]     mul_q, mul_d;
  logic               prev_q, prev_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic               ext_sgn;
  logic [OpW-1:0]     a_ext, x_ext;
  booth_digit_t       digit;
  logic [AccW-1:0]    a_acc, sel, addend, sum;
  logic [PairW-1:0]   pair_sh;
  logic               last_dig;

`ifdef MUL_SIGNED_EN
  assign ext_sgn = sgn;
`else
  assign ext_sgn = sgn & 1'b0;
`endif

  assign a_ext = {{2{ext_sgn & a[WIDTH-1]}}, a};
  assign x_ext = {{2{ext_sgn & x[WIDTH-1]}}, x};

  booth_r4_enc u_enc (
    .window ({mul_q[1:0], prev_q}),
    .digit  (digit)
  );

  // Datapath for one digit: acc += digit*a, then shift {acc, mul} right by 2.
  always_comb begin
    a_acc   = {{2{a_q[OpW-1]}}, a_q};
    sel     = digit.two ? (a_acc << 1) : (digit.one ? a_acc : '0);
    addend  = digit.neg ? (~sel + AccW'(1)) : sel;
    sum     = acc_q + addend;
    pair_sh = $signed({sum, mul_q}) >>> 2;
  end

  assign last_dig = (cnt_q == CntW'(NumDig - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mul_d   = mul_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_ext;
          mul_d   = x_ext;
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d  = pair_sh[PairW-1:OpW];
        mul_d  = pair_sh[OpW-1:0];
        prev_d = mul_q[1];
        if (last_dig) begin
          // Multiplier bits are fully shifted out: pair holds the exact product.
          p_d     = pair_sh[2*WIDTH-1:0];
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      mul_q   <= '0;
      prev_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mul_q   <= mul_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign p         = p_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH=32 and WIDTH=8.
// Expected products depend on whether MUL_SIGNED_EN is defined for the build.
module tb_booth_seq_multiplier;

  localparam int unsigned N32 = 17;
  localparam int unsigned N8  = 5;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, sgn, out_valid, out_ready, busy;
  logic [31:0] a, x;
  logic [63:0] p;

  logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, x8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .x         (x),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  booth_seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .x         (x8),
    .sgn       (sgn8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .p         (p8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept32(input string tag, input logic [31:0] av, input logic [31:0] xv,
                          input logic sv);
    @(negedge clk);
    a = av; x = xv; sgn = sv; in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs: the in-flight operands must be held internally.
    in_valid = 1'b0; a = 32'hDEAD_BEEF; x = 32'h1234_5678; sgn = ~sv;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic wait_done32(input string tag);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N32));
  endtask

  task automatic drain32(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] xv,
                       input logic sv, input logic [63:0] exp);
    accept32(tag, av, xv, sv);
    wait_done32(tag);
    check({tag, "_p"}, p, exp);
    drain32(tag);
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] xv,
                      input logic sv, input logic [15:0] exp);
    int lat = 0;
    @(negedge clk);
    a8 = av; x8 = xv; sgn8 = sv; in_valid8 = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; a8 = 8'h5A; x8 = 8'hC3; sgn8 = ~sv;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N8));
    check({tag, "_p"}, 64'(p8), 64'(exp));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    check({tag, "_idle_after"}, {62'd0, out_valid8, in_ready8}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; x = '0; sgn = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; x8 = '0; sgn8 = 1'b0;
    #12;
    check("rst_p", p, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef MUL_SIGNED_EN
    run32("neg10x5", 32'hFFFF_FFF6, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFCE);
    run32("ones_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run32("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
`else
    run32("neg10x5", 32'hFFFF_FFF6, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFCE);
    run32("ones_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    run32("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h7FFF_FFFF_8000_0000);
`endif
    run32("ones_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run32("min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

    // Backpressure: result held, new request ignored while DONE.
    accept32("bp", 32'd3, 32'd5, 1'b0);
    wait_done32("bp");
    check("bp_p", p, 64'd15);
    @(negedge clk);
    a = 32'd7; x = 32'd9; sgn = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {p[61:0], out_valid, in_ready}, {62'd15, 1'b1, 1'b0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; x = 32'hDEAD_BEEF;
    check("bp_second_accept", {62'd0, busy, in_ready}, 64'd2);
    wait_done32("bp2");
    check("bp2_p", p, 64'd63);
    drain32("bp2");

    // Reset while digit 8 is in progress aborts the transaction.
    accept32("abort", 32'h0001_0000, 32'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_pre_valid", 64'(out_valid), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {p[60:0], out_valid, busy, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);
    run32("post_abort", 32'd12345, 32'd6789, 1'b0, 64'd83810205);

`ifdef MUL_SIGNED_EN
    run8("w8_ff_x2", 8'hFF, 8'h02, 1'b1, 16'hFFFE);
    run8("w8_7_m3_s", 8'h07, 8'hFD, 1'b1, 16'hFFEB);
`else
    run8("w8_ff_x2", 8'hFF, 8'h02, 1'b1, 16'h01FE);
    run8("w8_7_m3_s", 8'h07, 8'hFD, 1'b1, 16'h06EB);
`endif
    run8("w8_7_fd_u", 8'h07, 8'hFD, 1'b0, 16'h06EB);
    run8("w8_min_min", 8'h80, 8'h80, 1'b1, 16'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
